// File: rtl/hpm_overflow_ctrl_pkg.sv
// Shared types for the HPM overflow/mode-filter control block: mhpmevent control
// byte layout, counter index offset and the privilege-mode inhibit selection.
package hpm_overflow_ctrl_pkg;

    localparam int unsigned HPM_CNT_OFFSET = 3;

    localparam int unsigned HPM_EVT_OF_BIT    = 7;
    localparam int unsigned HPM_EVT_MINH_BIT  = 6;
    localparam int unsigned HPM_EVT_SINH_BIT  = 5;
    localparam int unsigned HPM_EVT_UINH_BIT  = 4;
    localparam int unsigned HPM_EVT_VSINH_BIT = 3;
    localparam int unsigned HPM_EVT_VUINH_BIT = 2;

    typedef struct packed {
        logic       of;
        logic       minh;
        logic       sinh;
        logic       uinh;
        logic       vsinh;
        logic       vuinh;
        logic [1:0] rsvd;
    } hpm_evt_ctrl_t;

    typedef enum logic [1:0] {
        PRIV_LVL_U = 2'b00,
        PRIV_LVL_S = 2'b01,
        PRIV_LVL_M = 2'b11
    } priv_lvl_t;

    // The reserved encoding 2'b10 selects no inhibit bit.
    function automatic logic hpm_inhibit(input hpm_evt_ctrl_t ctrl,
                                         input logic [1:0]    priv,
                                         input logic          virt);
        logic inh;
        inh = 1'b0;
        case (priv)
            PRIV_LVL_M: inh = ctrl.minh;
            PRIV_LVL_S: inh = virt ? ctrl.vsinh : ctrl.sinh;
            PRIV_LVL_U: inh = virt ? ctrl.vuinh : ctrl.uinh;
            default:    inh = 1'b0;
        endcase
        return inh;
    endfunction

endpackage

// File: rtl/hpm_overflow_ctrl_lzc.sv
// Lowest-set-bit index finder used to pick the first overflowing counter
// when the overflow snapshot feature is built in.
module hpm_overflow_ctrl_lzc #(
    parameter int unsigned WIDTH = 29
) (
    input  logic [WIDTH-1:0] in_i,
    output logic [4:0]       idx_o,
    output logic             empty_o
);

    logic w_found;

    always_comb begin
        idx_o   = '0;
        w_found = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (in_i[i] && !w_found) begin
                idx_o   = 5'(i);
                w_found = 1'b1;
            end
        end
        empty_o = !w_found;
    end

endmodule

// File: rtl/hpm_overflow_ctrl.sv
// Sscofpmf overflow tracking, mode filtering and LCOFI generation for mhpmcounter3..31.
// Optional first-overflow snapshot ports under `HPM_OVF_SNAPSHOT_EN.
module hpm_overflow_ctrl
    import hpm_overflow_ctrl_pkg::*;
#(
    parameter int unsigned NumCounters = 29
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [1:0]             priv_lvl_i,
    input  logic                   v_i,
    input  logic                   debug_mode_i,
    input  logic [NumCounters-1:0] inc_i,
    input  logic [NumCounters-1:0] cnt_allones_i,
    output logic [NumCounters-1:0] count_en_o,
    input  logic                   evt_we_i,
    input  logic [4:0]             evt_idx_i,
    input  logic [7:0]             evt_wdata_i,
    output logic [7:0]             evt_rdata_o,
    output logic [31:0]            scountovf_o,
    output logic                   lcof_irq_o,
`ifdef HPM_OVF_SNAPSHOT_EN
    output logic [4:0]             ovf_first_idx_o,
    output logic                   ovf_first_vld_o,
`endif
    input  logic                   lcof_clr_i
);

    typedef enum logic {IDLE, PEND} state_e;

    state_e        r_state, w_state_d;
    hpm_evt_ctrl_t r_ctrl [NumCounters];
    hpm_evt_ctrl_t w_wr;
    logic [NumCounters-1:0] w_ovf, w_of_q, w_new;

    always_comb begin
        w_wr      = hpm_evt_ctrl_t'(evt_wdata_i);
        w_wr.rsvd = '0;
        w_ovf     = inc_i & cnt_allones_i;
        for (int unsigned i = 0; i < NumCounters; i++) begin
            w_of_q[i]     = r_ctrl[i].of;
            count_en_o[i] = !debug_mode_i && !hpm_inhibit(r_ctrl[i], priv_lvl_i, v_i);
        end
        w_new = w_ovf & ~w_of_q;
    end

    // Hardware overflow set takes priority over a same-cycle software write of OF.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NumCounters; i++) r_ctrl[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NumCounters; i++) begin
                if (evt_we_i && evt_idx_i == 5'(i)) begin
                    r_ctrl[i]    <= w_wr;
                    r_ctrl[i].of <= w_wr.of | w_ovf[i];
                end else if (w_ovf[i]) begin
                    r_ctrl[i].of <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        evt_rdata_o = '0;
        scountovf_o = '0;
        for (int unsigned i = 0; i < NumCounters; i++) begin
            if (evt_idx_i == 5'(i)) evt_rdata_o = r_ctrl[i];
            scountovf_o[i + HPM_CNT_OFFSET] = r_ctrl[i].of;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_state_d;
    end

    always_comb begin
        w_state_d  = r_state;
        lcof_irq_o = 1'b0;
        case (r_state)
            IDLE: if (|w_new) w_state_d = PEND;
            PEND: begin
                lcof_irq_o = 1'b1;
                if (lcof_clr_i && !(|w_new)) w_state_d = IDLE;
            end
            default: w_state_d = IDLE;
        endcase
    end

`ifdef HPM_OVF_SNAPSHOT_EN
    logic [4:0] w_first_idx;
    logic       w_first_empty;
    logic [4:0] r_first_idx;
    logic       r_first_vld;

    hpm_overflow_ctrl_lzc #(
        .WIDTH (NumCounters)
    ) u_lzc (
        .in_i    (w_new),
        .idx_o   (w_first_idx),
        .empty_o (w_first_empty)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_first_idx <= '0;
            r_first_vld <= 1'b0;
        end else if (r_state == IDLE && w_state_d == PEND && !w_first_empty) begin
            r_first_idx <= w_first_idx;
            r_first_vld <= 1'b1;
        end else if (r_state == PEND && w_state_d == IDLE) begin
            r_first_vld <= 1'b0;
        end
    end

    assign ovf_first_idx_o = r_first_idx;
    assign ovf_first_vld_o = r_first_vld;
`endif

endmodule

// File: doc/hpm_overflow_ctrl.md
# hpm_overflow_ctrl

Downstream companion to the hardware performance counter block, implementing Sscofpmf-style overflow tracking and mode filtering for mhpmcounter3..31. It holds the upper control byte of each mhpmevent CSR (OF and mode-inhibit bits). It gates counter increments by privilege mode, latches per-counter overflow flags, and raises the local counter-overflow interrupt (LCOFI) towards the CSR file. It sits between the perf counter block (increment pulses, all-ones flags) and csr_regfile (mip.LCOFIP, scountovf, CSR access).

## Interface
- NumCounters, default 29: number of programmable counters; internal index i maps to hpmcounter(i+3).
- clk_i  in  1  clock
- rst_ni  in  1  reset rst_ni, asynchronous, active-low; clock clk_i
- priv_lvl_i  in  2  current privilege (riscv::priv_lvl_t)
- v_i  in  1  virtualization mode active
- debug_mode_i  in  1  core in debug mode
- inc_i  in  NumCounters  increment actually applied to counter i this cycle
- cnt_allones_i  in  NumCounters  counter i currently equals 2^64-1
- count_en_o  out  NumCounters  mode-filter permit for counter i (to counter block)
- evt_we_i  in  1  write of the mhpmevent control byte
- evt_idx_i  in  5  counter index for read/write
- evt_wdata_i  in  8  mhpmevent[63:56]: OF, MINH, SINH, UINH, VSINH, VUINH, 2 reserved
- evt_rdata_o  out  8  control byte of counter evt_idx_i; combinational
- scountovf_o  out  32  bit i+3 = OF of counter i; bits 2:0 zero
- lcof_irq_o  out  1  LCOFI pending level (drives mip.LCOFIP)
- lcof_clr_i  in  1  software clear of mip.LCOFIP

## Operation
- Control byte per counter: OF (bit 7), MINH, SINH, UINH, VSINH, VUINH. Reserved bits read 0 and ignore writes.
- count_en_o[i] = !debug_mode_i & !inhibit(i). The inhibit bit is selected by mode: M→MINH, S&!v→SINH, U&!v→UINH, S&v→VSINH, U&v→VUINH.
- Overflow event ovf[i] = inc_i[i] & cnt_allones_i[i], i.e. the counter wraps to 0.
- OF update priority per counter: an overflow sets OF to 1. Otherwise, an evt_we_i write to that index loads OF from the written data. Otherwise OF holds. Hardware set wins over a simultaneous software clear.
- Writes to evt_idx_i ≥ NumCounters are ignored. Reads of such an index return 0.
- FSM with 2 states:
  - IDLE: lcof_irq_o=0. Go to PEND when any counter has ovf[i] & OF_q[i]==0, i.e. a 0→1 transition.
  - PEND: lcof_irq_o=1. Go to IDLE when lcof_clr_i is high and no new 0→1 OF transition occurs in the same cycle; otherwise stay.
- An overflow on a counter whose OF is already 1 does not re-raise the interrupt.
- An increment while debug_mode_i=1 is impossible by construction (count_en_o=0). Any such inc_i is still honoured for ovf.

## Timing
- Reset values: all control bytes 0, FSM IDLE, lcof_irq_o=0, scountovf_o=0.
- count_en_o and evt_rdata_o are combinational, with 0-cycle latency.
- OF, scountovf_o and lcof_irq_o update on the clock edge after the overflow cycle, giving 1-cycle latency.
- A software write is visible on evt_rdata_o in the cycle after evt_we_i.
- lcof_clr_i takes effect at the next edge.
- Asserting rst_ni mid-PEND drops lcof_irq_o immediately and clears all OF bits.

## Configuration
- HPM_OVF_SNAPSHOT_EN defined: adds ovf_first_idx_o (5 bits) and ovf_first_vld_o (1 bit).
  - On the IDLE→PEND transition, the block captures the lowest index among the newly overflowing counters.
  - ovf_first_vld_o is set with the capture and cleared on the PEND→IDLE transition.
  - The captured index holds while PEND, even if other counters overflow later.
- HPM_OVF_SNAPSHOT_EN undefined: the ports and logic are absent. The rest of the behaviour is identical.

## Structure
- ariane_pkg gets typedef hpm_evt_ctrl_t (packed struct of the 8 control bits) and localparams for the bit positions and HPM_CNT_OFFSET=3.
- The FSM state enum is local to the module.
- Sub-module: lzc from common_cells for first-index selection. It is instantiated only under HPM_OVF_SNAPSHOT_EN.

## Test plan
- Counter 4: write control byte 0x00, drive inc_i[4]=1 with cnt_allones_i[4]=1 → next cycle OF[4]=1, scountovf_o=0x80, lcof_irq_o=1.
- With the interrupt pending, overflow counter 4 again → lcof_irq_o stays 1. Pulse lcof_clr_i → IDLE. A further counter 4 overflow with OF still 1 → no new interrupt.
- Set MINH on counter 0, priv_lvl_i=M → count_en_o[0]=0. Switch to S with v_i=1 and VSINH=0 → count_en_o[0]=1. debug_mode_i=1 → all count_en_o=0.
- Same cycle: evt_we_i writes OF=0 to counter 2 and counter 2 overflows → OF[2]=1, IRQ raised.
- Counters 7 and 3 overflow in the same cycle from IDLE (snapshot enabled) → ovf_first_idx_o=3, ovf_first_vld_o=1. Assert rst_ni low mid-PEND → all outputs return to 0 immediately.
- Write evt_idx_i=30 → no state change. Read of index 30 → 0.
